stb_spi_master: RTL and testbench

- Byte-oriented SPI master that produces the SPI controller signals (spi_sclk, spi_ss, spi_mosi) and captures spi_miso.
- Sits directly upstream of the STB/DTB port switch, which routes these signals onto the plug GPIO/address pins in STB SPI mode.
- Always generates SPI mode 0 (sclk idles low). Clock inversion is applied downstream by the switch's spi_pol control bit.
- Driven by a CPU-side register interface using a start/busy/done handshake.

---
 rtl/stb_spi_pkg.sv | 20 ++
 rtl/stb_spi_clkgen.sv | 50 +++++
 rtl/stb_spi_master.sv | 182 ++++++++++++++++++
 tb/tb_stb_spi_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_spi_pkg.sv
// rtl/stb_spi_pkg.sv - shared state type and sizing constants for the STB SPI master
package stb_spi_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIV_W_DEF  = 8;
    localparam int BIT_CNT_W  = $clog2(DATA_W_DEF) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        WAIT
    } spi_state_e;

    function automatic int bit_cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/stb_spi_clkgen.sv
// rtl/stb_spi_clkgen.sv - half-period counter emitting tick plus sclk rise/fall strobes
module stb_spi_clkgen
    import stb_spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart_i,
    input  logic             en_i,
    input  logic             shift_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign tick_o = en_i & ~restart_i & (cnt_q == '0);
    // phase_q=0 means sclk currently low, so the next tick is a rising edge
    assign rise_o = tick_o & shift_i & ~phase_q;
    assign fall_o = tick_o & shift_i & phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = div_i;
            phase_d = 1'b0;
        end else if (en_i) begin
            cnt_d = tick_o ? div_i : cnt_q - DIV_W'(1);
            if (tick_o && shift_i) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/stb_spi_master.sv
// rtl/stb_spi_master.sv - byte-oriented SPI mode-0 master with start/busy/done handshake
// Optional: STB_SPI_MISO_LATE_EN samples miso on the falling sclk edge.
module stb_spi_master
    import stb_spi_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              last,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sclk,
    output logic              spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int CW = bit_cnt_width(DATA_W);

    spi_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_shifted;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              accept, tick, rise, fall, final_bit;
    logic              clk_en, in_shift;

    // A start coinciding with the done pulse is dropped on purpose
    assign accept     = start & ~done_q & ((state_q == IDLE) | (state_q == WAIT));
    assign final_bit  = (bit_cnt_q == CW'(DATA_W - 1));
    assign rx_shifted = {rx_sh_q[DATA_W-2:0], spi_miso};
    assign in_shift   = (state_q == SHIFT);
    assign clk_en     = (state_q == SETUP) | (state_q == SHIFT) | (state_q == HOLD);

    stb_spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart_i (accept),
        .en_i      (clk_en),
        .shift_i   (in_shift),
        .div_i     (accept ? div : div_q),
        .tick_o    (tick),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (tick) state_d = SHIFT;
            SHIFT:   if (fall && final_bit) state_d = last_q ? HOLD : WAIT;
            HOLD:    if (tick) state_d = IDLE;
            WAIT:    if (accept) state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d     = div_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;

        if (accept) begin
            div_d     = div;
            tx_sh_d   = tx_data;
            last_d    = last;
            rx_sh_d   = '0;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            ss_d      = 1'b1;
            mosi_d    = tx_data[DATA_W-1];
        end

        if (in_shift && rise) begin
            sclk_d = 1'b1;
`ifdef STB_SPI_MISO_LATE_EN
`else
            rx_sh_d = rx_shifted;
`endif
        end

        if (in_shift && fall) begin
            sclk_d = 1'b0;
`ifdef STB_SPI_MISO_LATE_EN
            rx_sh_d = rx_shifted;
`else
`endif
            if (final_bit) begin
                // mosi keeps the last bit; back-to-back bytes skip HOLD
                if (!last_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
`ifdef STB_SPI_MISO_LATE_EN
                    rx_d = rx_shifted;
`else
                    rx_d = rx_sh_q;
`endif
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                mosi_d    = tx_sh_q[DATA_W-2];
                tx_sh_d   = {tx_sh_q[DATA_W-2:0], tx_sh_q[DATA_W-1]};
            end
        end

        if ((state_q == HOLD) && tick) begin
            ss_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            rx_d   = rx_sh_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_q;
    assign spi_sclk = sclk_q;
    assign spi_ss   = ss_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_stb_spi_master.sv
// tb/tb_stb_spi_master.sv - self-checking bench for stb_spi_master with a cycle-level reference model
module tb_stb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] div, tx_data;
    logic       last, start;
    logic       busy, done, spi_sclk, spi_ss, spi_mosi, spi_miso;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;

    // miso source: 0 = loopback of mosi, 1 = tied high, 2 = pattern that changes after each rise
    int         mode = 0;
    logic       miso_r = 1'b0;
    logic       sclk_prev = 1'b0;
    int         pat_idx = 0;
    logic [7:0] pat = 8'h5A;

    always #5 clk = ~clk;

    assign spi_miso = (mode == 0) ? spi_mosi : (mode == 1) ? 1'b1 : miso_r;

    stb_spi_master dut (
        .clk      (clk),
        .reset_n  (rst_n),
        .div      (div),
        .tx_data  (tx_data),
        .last     (last),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .spi_sclk (spi_sclk),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always @(negedge clk) begin
        if (!spi_ss) begin
            pat_idx <= 0;
            miso_r  <= 1'b0;
        end else if (spi_sclk && !sclk_prev && pat_idx < 8) begin
            miso_r  <= pat[7-pat_idx];
            pat_idx <= pat_idx + 1;
        end
        sclk_prev <= spi_sclk;
    end

    // Reference model: t counts cycles since the accepting edge (t=1 is the first cycle after it)
    bit         m_have = 1'b0;
    bit         m_last = 1'b0;
    int         m_t = 0, m_H = 1, m_lead = 0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00, nxt_rx = 8'h00;
    int         me_end, me_u, me_bi;
    logic       e_busy, e_done, e_sclk, e_ss, e_mosi;
    logic [7:0] e_rx;

    always_comb begin
        e_busy = 1'b0;
        e_done = 1'b0;
        e_sclk = 1'b0;
        e_ss   = 1'b0;
        e_mosi = 1'b0;
        e_rx   = 8'h00;
        me_end = 0;
        me_u   = 0;
        me_bi  = 7;
        if (m_have) begin
            me_end = m_lead + 16 * m_H + (m_last ? m_H : 0) + 1;
            me_u   = m_t - m_lead - 1;
            e_busy = (m_t < me_end);
            e_done = (m_t == me_end);
            e_ss   = (m_t < me_end) || !m_last;
            e_sclk = (me_u >= 0) && (me_u < 16 * m_H) && ((me_u / m_H) % 2 == 1);
            if (me_u < 0) me_bi = 7;
            else me_bi = 7 - (((me_u / (2 * m_H)) > 7) ? 7 : (me_u / (2 * m_H)));
            e_mosi = m_tx[me_bi];
            e_rx   = m_rx;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
            m_last <= 1'b0;
            m_t    <= 0;
            m_H    <= 1;
            m_lead <= 0;
            m_tx   <= 8'h00;
            m_rx   <= 8'h00;
        end else if (start && !e_busy && !e_done) begin
            m_lead <= (m_have && !m_last) ? 0 : int'(div) + 1;
            m_H    <= int'(div) + 1;
            m_tx   <= tx_data;
            m_last <= last;
            m_rx   <= nxt_rx;
            m_t    <= 1;
            m_have <= 1'b1;
        end else if (m_have) begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({busy, done, spi_sclk, spi_ss, spi_mosi} !== {e_busy, e_done, e_sclk, e_ss, e_mosi}) begin
                errors++;
                $display("FAIL cycle_outputs t=%0d busy/done/sclk/ss/mosi: got %b required %b", m_t,
                         {busy, done, spi_sclk, spi_ss, spi_mosi}, {e_busy, e_done, e_sclk, e_ss, e_mosi});
            end
            if (!e_busy) begin
                checks++;
                if (rx_data !== e_rx) begin
                    errors++;
                    $display("FAIL cycle_rx_data t=%0d: got %h required %h", m_t, rx_data, e_rx);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic [7:0] tx, input logic l, input logic [7:0] erx,
                            input int poke_at, input logic [7:0] poke_div, input logic [7:0] poke_tx,
                            output int done_t, output int hi, output int pulses, output int ss_cnt,
                            output logic ss_done, output logic [7:0] cap);
        logic prev;
        done_t  = -1;
        hi      = 0;
        pulses  = 0;
        ss_cnt  = 0;
        ss_done = 1'b0;
        cap     = 8'h00;
        prev    = 1'b0;
        @(negedge clk);
        div = d; tx_data = tx; last = l; nxt_rx = erx; start = 1'b1;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            start = (n == poke_at);
            if (n == poke_at) begin
                div = poke_div; tx_data = poke_tx; last = ~l;
            end
            if (done) begin
                done_t  = n;
                ss_done = spi_ss;
                break;
            end
            if (spi_sclk) hi++;
            if (spi_sclk && !prev) begin
                pulses++;
                cap = {cap[6:0], spi_mosi};
            end
            if (spi_ss) ss_cnt++;
            prev = spi_sclk;
        end
        start = 1'b0;
        if (done_t < 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no done within 6000 cycles required done");
        end
    endtask

    int         dt, hi, pl, sc, dcount;
    logic       sd;
    logic [7:0] cp;
    logic [7:0] exp_pat_rx;

    initial begin
        rst_n = 1'b0; div = 8'h00; tx_data = 8'h00; last = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sclk", spi_sclk, 0);
        chk("reset_ss", spi_ss, 0);
        chk("reset_mosi", spi_mosi, 0);
        chk("reset_rx", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 0;
        run_xfer(8'd0, 8'hA5, 1'b1, 8'hA5, 0, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("t1_done_cycle", dt, 19);
        chk("t1_rx", rx_data, 8'hA5);
        chk("t1_pulses", pl, 8);
        chk("t1_sclk_high_cycles", hi, 8);
        chk("t1_ss_high_cycles", sc, 18);
        chk("t1_ss_at_done", sd, 0);
        repeat (3) @(negedge clk);

        mode = 1;
        run_xfer(8'd3, 8'h3C, 1'b1, 8'hFF, 20, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("t2_done_cycle", dt, 73);
        chk("t2_rx", rx_data, 8'hFF);
        chk("t2_pulses", pl, 8);
        chk("t2_sclk_high_cycles", hi, 32);
        repeat (3) @(negedge clk);

        mode = 0;
        run_xfer(8'd1, 8'h12, 1'b0, 8'h12, 0, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("t3a_done_cycle", dt, 35);
        chk("t3a_ss_at_done", sd, 1);
        chk("t3a_rx", rx_data, 8'h12);
        start = 1'b1; tx_data = 8'h77; last = 1'b1;
        run_xfer(8'd1, 8'h34, 1'b1, 8'h34, 0, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("t3b_done_cycle", dt, 35);
        chk("t3b_ss_high_cycles", sc, 34);
        chk("t3b_ss_at_done", sd, 0);
        chk("t3b_rx", rx_data, 8'h34);
        chk("t3b_mosi_bits", cp, 8'h34);
        repeat (3) @(negedge clk);

        run_xfer(8'd0, 8'hC3, 1'b1, 8'hC3, 5, 8'd7, 8'h0F, dt, hi, pl, sc, sd, cp);
        chk("t4_done_cycle", dt, 19);
        chk("t4_mosi_bits", cp, 8'hC3);
        chk("t4_rx", rx_data, 8'hC3);
        repeat (3) @(negedge clk);

`ifdef STB_SPI_MISO_LATE_EN
        exp_pat_rx = 8'h5A;
`else
        exp_pat_rx = 8'h2D;
`endif
        mode = 2;
        run_xfer(8'd1, 8'h00, 1'b1, exp_pat_rx, 0, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("t5_done_cycle", dt, 37);
        chk("t5_rx_pattern", rx_data, exp_pat_rx);
        repeat (3) @(negedge clk);

        mode = 0;
        run_xfer(8'd255, 8'h81, 1'b1, 8'h81, 0, 8'd0, 8'h00, dt, hi, pl, sc, sd, cp);
        chk("tmax_done_cycle", dt, 4609);
        chk("tmax_sclk_high_cycles", hi, 2048);
        chk("tmax_rx", rx_data, 8'h81);
        repeat (3) @(negedge clk);

        @(negedge clk);
        div = 8'd2; tx_data = 8'hF0; last = 1'b1; nxt_rx = 8'hF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_sclk", spi_sclk, 0);
        chk("mid_reset_ss", spi_ss, 0);
        chk("mid_reset_mosi", spi_mosi, 0);
        chk("mid_reset_rx", rx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("no_done_after_reset", dcount, 0);
        chk("idle_after_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
